// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: controller state encoding and default iteration count.
package cordic_pkg;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_ITER,
        CTRL_CAPT
    } cordic_ctrl_state_e;

    localparam int CORDIC_N_ITER_DEF = 16;

endpackage

// File: rtl/cordic_iter_ctrl.sv
// Iteration sequencer for the CORDIC datapath: accepts one job, steps the stage index,
// then parks the final x/y/z in a result register with valid/ready backpressure.
//
// state     | meaning
// CTRL_IDLE | waiting for a job; s_ready high unless flushing
// CTRL_ITER | datapath enabled, dp_iter = current micro-rotation index
// CTRL_CAPT | datapath frozen; waits until the result register is free, then loads it
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int XY_W    = 16,
    parameter int XYI     = 19,
    parameter int ANGLE_W = 32,
    parameter int N_ITER  = CORDIC_N_ITER_DEF,
    localparam int ITER_W = (N_ITER > 1) ? $clog2(N_ITER) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_mode,
    output logic               dp_ce,
    output logic               dp_load,
    output logic [ITER_W-1:0]  dp_iter,
    output logic               dp_mode,
    input  logic [XYI:0]       dp_x,
    input  logic [XYI:0]       dp_y,
    input  logic [ANGLE_W-1:0] dp_z,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [XYI:0]       m_x,
    output logic [XYI:0]       m_y,
    output logic [ANGLE_W-1:0] m_z,
    output logic               busy
);

    localparam logic [ITER_W-1:0] LAST_CNT = ITER_W'(N_ITER - 1);

    // The shift amount must stay inside the internal x/y word.
    if (N_ITER < 1 || N_ITER > XYI || XYI + 1 < XY_W) begin : g_bad_param
        $error("cordic_iter_ctrl: illegal N_ITER/XYI/XY_W combination");
    end

    cordic_ctrl_state_e state_q, state_d;
    logic [ITER_W-1:0]  cnt_q, cnt_d;
    logic               capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CTRL_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_ready = 1'b0;
        dp_ce   = 1'b0;
        dp_load = 1'b0;
        dp_iter = '0;
        capture = 1'b0;
        case (state_q)
            CTRL_IDLE: begin
                s_ready = !flush;
                if (s_valid && !flush) begin
                    dp_load = 1'b1;
                    dp_ce   = 1'b1;
                    cnt_d   = '0;
                    state_d = CTRL_ITER;
                end
            end
            CTRL_ITER: begin
                dp_ce   = 1'b1;
                dp_iter = cnt_q;
                cnt_d   = cnt_q + ITER_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = CTRL_CAPT;
                end
            end
            CTRL_CAPT: begin
                if (!m_valid || m_ready) begin
                    capture = 1'b1;
                    state_d = CTRL_IDLE;
                end
            end
            default: state_d = CTRL_IDLE;
        endcase
        // Abort wins over everything, including a capture or accept in the same cycle.
        if (flush) begin
            state_d = CTRL_IDLE;
            cnt_d   = '0;
            s_ready = 1'b0;
            dp_ce   = 1'b0;
            dp_load = 1'b0;
            capture = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_mode <= 1'b0;
        end else if (dp_load) begin
            dp_mode <= s_mode;
        end
    end

    // Reload takes priority over consume so back-to-back results never drop a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_x     <= '0;
            m_y     <= '0;
            m_z     <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (capture) begin
            m_valid <= 1'b1;
            m_x     <= dp_x;
            m_y     <= dp_y;
            m_z     <= dp_z;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

    assign busy = (state_q != CTRL_IDLE) || m_valid;

    a_load_ce : assert property (@(posedge clk) disable iff (!rst_n)
        dp_load |-> dp_ce);
    a_mode_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != CTRL_IDLE) |=> $stable(dp_mode));
    a_result_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready) |=> $stable({m_x, m_y, m_z}));

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for cordic_iter_ctrl with a behavioural datapath and result scoreboard.
module tb_cordic_iter_ctrl;

    localparam int XYI     = 19;
    localparam int ANGLE_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance (N_ITER = 16)
    logic               flush, s_valid, s_ready, s_mode;
    logic               dp_ce, dp_load, dp_mode;
    logic [3:0]         dp_iter;
    logic [XYI:0]       dp_x = '0, dp_y = '0;
    logic [ANGLE_W-1:0] dp_z = '0;
    logic               m_valid, m_ready, busy;
    logic [XYI:0]       m_x, m_y;
    logic [ANGLE_W-1:0] m_z;
    logic [XYI:0]       seed;

    cordic_iter_ctrl #(.XY_W(16), .XYI(XYI), .ANGLE_W(ANGLE_W), .N_ITER(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_mode(s_mode),
        .dp_ce(dp_ce), .dp_load(dp_load), .dp_iter(dp_iter), .dp_mode(dp_mode),
        .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z),
        .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y), .m_z(m_z),
        .busy(busy)
    );

    // Single-iteration instance
    logic               s_valid1, s_ready1, dp_ce1, dp_load1, dp_mode1;
    logic [0:0]         dp_iter1;
    logic               m_valid1, m_ready1, busy1;
    logic [XYI:0]       m_x1, m_y1;
    logic [ANGLE_W-1:0] m_z1;

    cordic_iter_ctrl #(.XY_W(16), .XYI(XYI), .ANGLE_W(ANGLE_W), .N_ITER(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .s_valid(s_valid1), .s_ready(s_ready1), .s_mode(1'b0),
        .dp_ce(dp_ce1), .dp_load(dp_load1), .dp_iter(dp_iter1), .dp_mode(dp_mode1),
        .dp_x(20'h2468A), .dp_y(20'h13579), .dp_z(32'hCAFE_0001),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_x(m_x1), .m_y(m_y1), .m_z(m_z1),
        .busy(busy1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Closed-form result of the bench datapath after one load and 16 enabled steps.
    function automatic logic [XYI:0] exp_x(input logic [XYI:0] s);
        return s + 20'h0FFFF;
    endfunction
    function automatic logic [XYI:0] exp_y(input logic [XYI:0] s);
        return ~s + 20'd120;
    endfunction
    function automatic logic [ANGLE_W-1:0] exp_z(input logic [XYI:0] s);
        return {12'd0, s} * 32'd3 + 32'd16;
    endfunction

    // Datapath model: control sampled mid-cycle, applied on the next rising edge.
    logic       ld_s = 1'b0, ce_s = 1'b0;
    logic [3:0] it_s = '0;
    logic [XYI:0] seed_s = '0;
    logic [XYI:0] sb_q[$];

    always @(negedge clk) begin
        ld_s   <= dp_load;
        ce_s   <= dp_ce;
        it_s   <= dp_iter;
        seed_s <= seed;
        if (!rst_n || flush) begin
            sb_q.delete();
        end else begin
            if (dp_load) sb_q.push_back(seed);
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    chk("sb_x", m_x, exp_x(sb_q[0]));
                    chk("sb_y", m_y, exp_y(sb_q[0]));
                    chk("sb_z", m_z, exp_z(sb_q[0]));
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    always @(posedge clk) begin
        if (ld_s) begin
            dp_x <= seed_s;
            dp_y <= ~seed_s;
            dp_z <= {12'd0, seed_s} * 32'd3;
        end else if (ce_s) begin
            dp_x <= dp_x + (20'd1 << it_s);
            dp_y <= dp_y + 20'(it_s);
            dp_z <= dp_z + 32'd1;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            next_cycle();
            k++;
        end
        chk("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] ld_mask, mv_mask;
        logic        mv_seen;
        logic [XYI:0] seed_a, seed_b;

        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_mode = 1'b0; m_ready = 1'b1;
        seed = '0; s_valid1 = 1'b0; m_ready1 = 1'b1;
        next_cycle();
        #1;
        chk("rst_outs", {dp_ce, dp_load, dp_iter, dp_mode, m_valid, busy, s_ready},
            {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        chk("rst_mx", {m_x, m_y, m_z}, 64'd0);
        next_cycle();
        rst_n = 1'b1;

        // Single job
        next_cycle();
        s_valid = 1'b1; seed = 20'h0ABCD; #1;
        chk("t1_load_c0", {dp_load, dp_ce}, 2'b11);
        for (int i = 1; i <= 16; i++) begin
            next_cycle();
            s_valid = 1'b0; #1;
            chk("t1_iter", {dp_ce, dp_load, s_ready, dp_iter}, {3'b100, 4'(i - 1)});
        end
        next_cycle(); #1;
        chk("t1_capt", {dp_ce, m_valid, busy}, 3'b001);
        next_cycle(); #1;
        chk("t1_mvalid", {m_valid, s_ready}, 2'b11);
        chk("t1_mx", m_x, exp_x(20'h0ABCD));

        // Streaming with s_valid held high
        ld_mask = '0; mv_mask = '0;
        for (int i = 0; i <= 36; i++) begin
            next_cycle();
            s_valid = 1'b1; seed = 20'h10000 + 20'(i * 7); #1;
            if (dp_load) ld_mask[i] = 1'b1;
            if (m_valid) mv_mask[i] = 1'b1;
        end
        chk("t2_accepts", ld_mask, 64'h0000_0010_0004_0001);
        chk("t2_mvalid", mv_mask, 64'h0000_0010_0004_0000);
        next_cycle();
        s_valid = 1'b0;
        wait_idle();

        // Backpressure
        seed_a = 20'h3C3C3; seed_b = 20'h5A5A5;
        for (int i = 0; i <= 51; i++) begin
            next_cycle();
            s_valid = (i <= 18);
            seed    = (i < 18) ? seed_a : seed_b;
            m_ready = (i >= 50);
            #1;
            if (i == 18) chk("t3_accept_b", {dp_load, m_valid}, 2'b11);
            if (i == 35 || i == 49) begin
                chk("t3_stall", {dp_ce, busy, m_valid, s_ready}, 4'b0110);
                chk("t3_hold_a", m_x, exp_x(seed_a));
            end
            if (i == 51) chk("t3_b_out", {m_valid, m_x}, {1'b1, exp_x(seed_b)});
        end
        s_valid = 1'b0;
        wait_idle();

        // Flush mid-iteration
        mv_seen = 1'b0;
        for (int i = 0; i <= 26; i++) begin
            next_cycle();
            s_valid = (i == 0); seed = 20'h77777; flush = (i == 6); #1;
            if (m_valid) mv_seen = 1'b1;
            if (i == 6) chk("t4_flush_c6", {dp_ce, dp_load, s_ready, dp_iter}, {3'b000, 4'd5});
            if (i == 7) chk("t4_idle_c7", {s_ready, busy, dp_ce}, 3'b100);
        end
        chk("t4_no_result", {63'd0, mv_seen}, 64'd0);

        // Mode latch and async reset mid-job
        for (int i = 0; i <= 9; i++) begin
            next_cycle();
            s_valid = (i == 0); seed = 20'h01234;
            s_mode  = (i == 0) ? 1'b1 : 1'(i & 1);
            if (i == 9) rst_n = 1'b0;
            #1;
            if (i >= 1 && i <= 8) chk("t5_mode", {63'd0, dp_mode}, 64'd1);
        end
        chk("t5_rst_outs", {dp_ce, dp_load, dp_iter, dp_mode, m_valid, busy, s_ready},
            {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        next_cycle();
        rst_n = 1'b1; s_mode = 1'b0;
        next_cycle(); #1;
        chk("t5_after_rel", {s_ready, busy, m_valid, dp_mode}, 4'b1000);
        mv_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            if (m_valid) mv_seen = 1'b1;
        end
        chk("t5_no_result", {63'd0, mv_seen}, 64'd0);

        // Single-iteration build
        for (int i = 0; i <= 3; i++) begin
            next_cycle();
            s_valid1 = (i == 0); #1;
            if (i == 0) chk("t6_load", {dp_load1, dp_ce1}, 2'b11);
            if (i == 1) chk("t6_iter", {dp_ce1, dp_load1, dp_iter1, s_ready1}, 4'b1000);
            if (i == 2) chk("t6_capt", {dp_ce1, m_valid1, busy1}, 3'b001);
            if (i == 3) chk("t6_result", {m_valid1, m_x1, m_z1}, {1'b1, 20'h2468A, 32'hCAFE_0001});
        end

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
